// File: rtl/muldiv_pkg.sv
// Shared types for the EX-stage multiply/divide unit.
//   muldiv_op_t : decoded HI/LO operation of the instruction in EX
//   md_state_t  : control state of ex_muldiv (IDLE, MUL, DIV)
//   MD_WIDTH    : default operand / HI / LO width
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [3:0] {
    MD_NONE,
    MD_MULT,
    MD_MULTU,
    MD_DIV,
    MD_DIVU,
    MD_MTHI,
    MD_MTLO,
    MD_MFHI,
    MD_MFLO
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV
  } md_state_t;

  // Signed ops work on operand magnitudes and fix the signs at the end.
  function automatic logic is_signed_op(input muldiv_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Pipeline-side bundle of the multiply/divide unit.
//   master : EX stage (drives Op, A, B, Hold; observes the rest)
//   slave  : ex_muldiv
//   Op/A/B    : instruction in EX and its forwarded operands
//   Hold      : downstream stall (must not contain Stall)
//   Stall     : EX instruction must wait (comb)
//   Busy      : iteration in progress (registered)
//   Hi/Lo     : architectural HI/LO
//   HiLoData  : MFHI/MFLO read data (comb)
//   DbgState  : current control state, for observation only
//
// Handshake: Op != MD_NONE acts as "valid". A muldiv/MTxx op is taken on a
// posedge with state IDLE and Hold low ("ready"); it then leaves EX and is
// never presented again. While Busy, every op in EX sees Stall=1 and must be
// held unchanged by the ID/EX register until Stall drops.
interface ex_muldiv_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
);
  muldiv_op_t       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Hold;
  logic             Stall;
  logic             Busy;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic [WIDTH-1:0] HiLoData;
  md_state_t        DbgState;

  modport master (
    output Op, A, B, Hold,
    input  Stall, Busy, Hi, Lo, HiLoData, DbgState
  );

  modport slave (
    input  Op, A, B, Hold,
    output Stall, Busy, Hi, Lo, HiLoData, DbgState
  );
endinterface

// File: rtl/ex_muldiv_divcore.sv
// Restoring-divide datapath: one quotient bit per enabled cycle.
//   CLK, RST  : clock, synchronous active-high reset
//   load      : capture dividend/divisor, clear partial remainder
//   step      : perform one restoring step
//   dividend  : unsigned dividend magnitude
//   divisor   : unsigned divisor magnitude
//   quo_step  : quotient register after the current step (comb)
//   rem_step  : remainder register after the current step (comb)
// The step values are exposed so the caller can write the final result on
// the same edge as the last step. A zero divisor naturally yields an
// all-ones quotient and a remainder equal to the dividend.
module ex_muldiv_divcore #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quo_step,
  output logic [WIDTH-1:0] rem_step
);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvsr_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             take;

  // Remainder is always < divisor, so a borrow shows up as diff[WIDTH].
  assign shifted  = {rem_q, quo_q[WIDTH-1]};
  assign diff     = shifted - {1'b0, dvsr_q};
  assign take     = ~diff[WIDTH];
  assign rem_step = take ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_step = {quo_q[WIDTH-2:0], take};

  always_ff @(posedge CLK) begin
    if (RST) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
    end else if (load) begin
      rem_q  <= '0;
      quo_q  <= dividend;
      dvsr_q <= divisor;
    end else if (step) begin
      rem_q  <= rem_step;
      quo_q  <= quo_step;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage iterative multiply/divide unit holding the architectural HI/LO.
//   CLK, RST : clock, synchronous active-high reset
//   md       : ex_muldiv_if.slave (Op, A, B, Hold in; Stall, Busy, Hi, Lo,
//              HiLoData, DbgState out)
// Multiply is shift-add, divide is restoring (ex_muldiv_divcore); both take
// WIDTH cycles and write HI/LO on the last one.
// Build option MULDIV_FAST_MUL_EN: multiply completes in a single cycle
// using an array multiplier; divide is unaffected.
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = 6
) (
  input logic        CLK,
  input logic        RST,
  ex_muldiv_if.slave md
);

`ifdef MULDIV_FAST_MUL_EN
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(1);
`else
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(WIDTH);
`endif
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(WIDTH);

  md_state_t            state;
  logic [CNT_W-1:0]     cnt;
  logic                 busy_q;
  logic [WIDTH-1:0]     hi_q, lo_q;
  logic                 neg_res_q, neg_rem_q, dbz_q;
  logic [WIDTH-1:0]     a_q, mcand_q;
  logic [2*WIDTH-1:0]   prod_q, prod_nxt, prod_fix;
  logic [WIDTH-1:0]     quo_step, rem_step, quo_fix, rem_fix;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic                 op_signed, a_neg, b_neg, last, div_load;

  assign op_signed = is_signed_op(md.Op);
  assign a_neg     = op_signed & md.A[WIDTH-1];
  assign b_neg     = op_signed & md.B[WIDTH-1];
  assign a_mag     = a_neg ? -md.A : md.A;
  assign b_mag     = b_neg ? -md.B : md.B;
  assign last      = (cnt == CNT_W'(1));
  assign div_load  = (state == IDLE) && !md.Hold &&
                     ((md.Op == MD_DIV) || (md.Op == MD_DIVU));

  // prod_q starts as {0, multiplier}; the multiplier bits shift out of the
  // bottom while partial sums enter at the top.
`ifdef MULDIV_FAST_MUL_EN
  assign prod_nxt = {{WIDTH{1'b0}}, mcand_q} * prod_q;
`else
  logic [WIDTH:0] mul_sum;
  assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                    {1'b0, (prod_q[0] ? mcand_q : {WIDTH{1'b0}})};
  assign prod_nxt = {mul_sum, prod_q[WIDTH-1:1]};
`endif

  // Sign fix-up; divide by zero overrides to HI=A, LO=all ones.
  assign prod_fix = neg_res_q ? -prod_nxt : prod_nxt;
  assign quo_fix  = dbz_q ? {WIDTH{1'b1}} : (neg_res_q ? -quo_step : quo_step);
  assign rem_fix  = dbz_q ? a_q : (neg_rem_q ? -rem_step : rem_step);

  ex_muldiv_divcore #(.WIDTH(WIDTH)) u_divcore (
    .CLK      (CLK),
    .RST      (RST),
    .load     (div_load),
    .step     (state == DIV),
    .dividend (a_mag),
    .divisor  (b_mag),
    .quo_step (quo_step),
    .rem_step (rem_step)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      a_q       <= '0;
      mcand_q   <= '0;
      prod_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!md.Hold) begin
            case (md.Op)
              MD_MULT, MD_MULTU: begin
                state     <= MUL;
                cnt       <= MUL_CNT;
                busy_q    <= 1'b1;
                mcand_q   <= a_mag;
                prod_q    <= {{WIDTH{1'b0}}, b_mag};
                neg_res_q <= a_neg ^ b_neg;
              end
              MD_DIV, MD_DIVU: begin
                state     <= DIV;
                cnt       <= DIV_CNT;
                busy_q    <= 1'b1;
                neg_res_q <= a_neg ^ b_neg;
                neg_rem_q <= a_neg;
                dbz_q     <= (md.B == '0);
                a_q       <= md.A;
              end
              MD_MTHI: hi_q <= md.A;
              MD_MTLO: lo_q <= md.A;
              default: ;
            endcase
          end
        end
        MUL: begin
          prod_q <= prod_nxt;
          cnt    <= cnt - CNT_W'(1);
          if (last) begin
            {hi_q, lo_q} <= prod_fix;
            state        <= IDLE;
            busy_q       <= 1'b0;
          end
        end
        DIV: begin
          cnt <= cnt - CNT_W'(1);
          if (last) begin
            hi_q   <= rem_fix;
            lo_q   <= quo_fix;
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign md.Stall    = busy_q & (md.Op != MD_NONE);
  assign md.Busy     = busy_q;
  assign md.Hi       = hi_q;
  assign md.Lo       = lo_q;
  assign md.DbgState = state;

  always_comb begin
    md.HiLoData = '0;
    if (md.Op == MD_MFHI)      md.HiLoData = hi_q;
    else if (md.Op == MD_MFLO) md.HiLoData = lo_q;
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Testbench for ex_muldiv: vector table, hand-written corner sequences and
// random operations checked against an arithmetic reference model.
module tb_ex_muldiv;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 32;
`endif
  localparam int DIV_LAT = 32;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  ex_muldiv_if md ();

  ex_muldiv dut (
    .CLK (CLK),
    .RST (RST),
    .md  (md)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: returns {HI, LO} from plain arithmetic.
  function automatic logic [63:0] ref_model(input muldiv_op_t op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint p;
    int     sa, sb;
    logic [31:0] q, r;
    case (op)
      MD_MULT: begin
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
      end
      MD_MULTU: return {32'h0, a} * {32'h0, b};
      MD_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      MD_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sa = a;
        sb = b;
        q  = sa / sb;
        r  = sa % sb;
        return {r, q};
      end
      default: return 64'h0;
    endcase
  endfunction

  function automatic int lat_of(input muldiv_op_t op);
    return (op == MD_MULT || op == MD_MULTU) ? MUL_LAT : DIV_LAT;
  endfunction

  // ---------------- driver tasks ----------------
  // Presents op for one edge; returns at the negedge after the accept edge.
  task automatic issue(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
    @(negedge CLK);
    md.Op = op;
    md.A  = a;
    md.B  = b;
    @(negedge CLK);
    md.Op = MD_NONE;
  endtask

  // Called at the negedge after the accept edge; checks Busy, latency and HI/LO.
  task automatic finish_op(input string name, input int lat);
    int          cyc;
    logic [63:0] exp;
    cyc = 0;
    check({name, "_busy_rise"}, 64'(md.Busy), 64'd1);
    while (md.Busy === 1'b1 && cyc < 100) begin
      @(negedge CLK);
      cyc++;
    end
    check({name, "_latency"}, 64'(cyc), 64'(lat));
    exp = exp_q.pop_front();
    check({name, "_hilo"}, {md.Hi, md.Lo}, exp);
  endtask

  task automatic do_op(input string name, input muldiv_op_t op, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp);
    exp_q.push_back(exp);
    issue(op, a, b);
    finish_op(name, lat_of(op));
  endtask

  // MFHI/MFLO read-back while idle.
  task automatic read_hilo(input string name, input logic [63:0] exp);
    md.Op = MD_MFHI;
    #1;
    check({name, "_mfhi"}, {32'h0, md.HiLoData}, {32'h0, exp[63:32]});
    md.Op = MD_MFLO;
    #1;
    check({name, "_mflo"}, {32'h0, md.HiLoData}, {32'h0, exp[31:0]});
    check({name, "_nostall"}, 64'(md.Stall), 64'd0);
    md.Op = MD_NONE;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    muldiv_op_t  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1);
  end

  initial begin
    logic [63:0] exp;
    muldiv_op_t  rop;
    logic [31:0] ra, rb;
    int          cnt;

    vecs[0] = '{MD_MULT,  32'hFFFF_FFFB, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[1] = '{MD_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[2] = '{MD_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
    vecs[3] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[4] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[5] = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[6] = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[7] = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[8] = '{MD_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};
    vecs[9] = '{MD_MULT,  32'h0000_0006, 32'h0000_0007, 32'h0000_0000, 32'h0000_002A};

    md.Op   = MD_NONE;
    md.A    = '0;
    md.B    = '0;
    md.Hold = 1'b0;
    RST     = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;

    // Reset state
    check("rst_hilo", {md.Hi, md.Lo}, 64'h0);
    check("rst_busy", 64'(md.Busy), 64'd0);
    check("rst_stall", 64'(md.Stall), 64'd0);
    check("rst_state", 64'(md.DbgState), 64'(IDLE));

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo});
      read_hilo($sformatf("vec%0d", i), {vecs[i].hi, vecs[i].lo});
    end

    // MTHI / MTLO then reads
    issue(MD_MTHI, 32'h1234_5678, 32'h0);
    check("mthi_busy", 64'(md.Busy), 64'd0);
    issue(MD_MTLO, 32'h9ABC_DEF0, 32'h0);
    read_hilo("mtxx", 64'h1234_5678_9ABC_DEF0);

    // MFLO arriving one cycle after a MULTU issue
    exp = ref_model(MD_MULTU, 32'h0001_0003, 32'h0000_F00F);
    issue(MD_MULTU, 32'h0001_0003, 32'h0000_F00F);
    check("mflo_busy_rise", 64'(md.Busy), 64'd1);
    @(negedge CLK);
    md.Op = MD_MFLO;
    #1;
    cnt = 0;
    while (md.Stall === 1'b1 && cnt < 100) begin
      @(negedge CLK);
      cnt++;
    end
    check("mflo_stall_cycles", 64'(cnt), 64'(MUL_LAT - 1));
    check("mflo_stall_low", 64'(md.Stall), 64'd0);
    check("mflo_data", {32'h0, md.HiLoData}, {32'h0, exp[31:0]});
    md.Op = MD_NONE;

    // Hold blocks acceptance
    @(negedge CLK);
    md.Op   = MD_MULT;
    md.A    = 32'hFFFF_FFF7;
    md.B    = 32'h0000_1000;
    md.Hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check($sformatf("hold_busy%0d", i), 64'(md.Busy), 64'd0);
    end
    md.Hold = 1'b0;
    exp_q.push_back(ref_model(MD_MULT, 32'hFFFF_FFF7, 32'h0000_1000));
    @(negedge CLK);
    md.Op = MD_NONE;
    finish_op("hold", MUL_LAT);

    // Reset in the middle of a divide
    issue(MD_DIV, 32'h0000_03E8, 32'h0000_0007);
    repeat (9) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("midrst_busy", 64'(md.Busy), 64'd0);
    check("midrst_hilo", {md.Hi, md.Lo}, 64'h0);
    check("midrst_state", 64'(md.DbgState), 64'(IDLE));
    repeat (40) @(negedge CLK);
    check("midrst_no_late_write", {md.Hi, md.Lo}, 64'h0);
    do_op("post_rst_mult", MD_MULT, 32'hFFFF_FF9C, 32'h0000_0123,
          ref_model(MD_MULT, 32'hFFFF_FF9C, 32'h0000_0123));

    // Random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       rop = MD_MULT;
        1:       rop = MD_MULTU;
        2:       rop = MD_DIV;
        default: rop = MD_DIVU;
      endcase
      case ($urandom_range(0, 5))
        0:       ra = 32'h8000_0000;
        1:       ra = $urandom_range(0, 100);
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = $urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      do_op($sformatf("rnd%0d", i), rop, ra, rb, ref_model(rop, ra, rb));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
